// File: rtl/vga_sync_gen.sv
// vga_sync_gen: free-running VGA raster counters with registered, count-aligned sync/blank decode.
// Outputs are decoded from the next-count values, so they always describe the DrawX/DrawY shown in the same cycle.
module vga_sync_gen #(
    parameter int H_VISIBLE = 640,
    parameter int H_FRONT   = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BACK    = 48,
    parameter int V_VISIBLE = 480,
    parameter int V_FRONT   = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BACK    = 33
) (
    input  logic       vga_clk,
    input  logic       reset,
    output logic [9:0] DrawX,
    output logic [9:0] DrawY,
    output logic       hs,
    output logic       vs,
    output logic       blank,
    output logic       line_start,
    output logic       frame_start,
    output logic [7:0] frame_count
);
    localparam logic [9:0] H_LAST = 10'(H_VISIBLE + H_FRONT + H_SYNC + H_BACK - 1);
    localparam logic [9:0] V_LAST = 10'(V_VISIBLE + V_FRONT + V_SYNC + V_BACK - 1);
    localparam logic [9:0] H_VIS  = 10'(H_VISIBLE);
    localparam logic [9:0] V_VIS  = 10'(V_VISIBLE);
    localparam logic [9:0] HS_BEG = 10'(H_VISIBLE + H_FRONT);
    localparam logic [9:0] HS_END = 10'(H_VISIBLE + H_FRONT + H_SYNC - 1);
    localparam logic [9:0] VS_BEG = 10'(V_VISIBLE + V_FRONT);
    localparam logic [9:0] VS_END = 10'(V_VISIBLE + V_FRONT + V_SYNC - 1);

    logic       w_x_wrap;
    logic [9:0] w_x_nxt;
    logic [9:0] w_y_nxt;
    logic       w_frame;

    always_comb begin
        w_x_wrap = DrawX == H_LAST;
        w_x_nxt  = w_x_wrap ? 10'd0 : DrawX + 10'd1;
        w_y_nxt  = !w_x_wrap ? DrawY : (DrawY == V_LAST ? 10'd0 : DrawY + 10'd1);
        w_frame  = w_x_nxt == 10'd0 && w_y_nxt == 10'd0;
    end

    // Reset parks the raster on its last pixel so the first edge enters (0,0) as a new frame.
    always_ff @(posedge vga_clk or posedge reset) begin
        if (reset) begin
            DrawX       <= H_LAST;
            DrawY       <= V_LAST;
            hs          <= 1'b1;
            vs          <= 1'b1;
            blank       <= 1'b0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
            frame_count <= 8'd0;
        end else begin
            DrawX       <= w_x_nxt;
            DrawY       <= w_y_nxt;
            hs          <= !(w_x_nxt >= HS_BEG && w_x_nxt <= HS_END);
            vs          <= !(w_y_nxt >= VS_BEG && w_y_nxt <= VS_END);
            blank       <= w_x_nxt < H_VIS && w_y_nxt < V_VIS;
            line_start  <= w_x_nxt == 10'd0;
            frame_start <= w_frame;
            if (w_frame)
                frame_count <= frame_count + 8'd1;
        end
    end
endmodule

// File: tb/tb_vga_sync_gen.sv
// tb_vga_sync_gen: directed table plus per-cycle raster model for a default-size and a reduced-size instance.
module tb_vga_sync_gen;
    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", nm, act, exp, $time);
        end
    endtask

    logic [9:0] d_x, d_y, s_x, s_y;
    logic d_hs, d_vs, d_bl, d_ls, d_fs, s_hs, s_vs, s_bl, s_ls, s_fs;
    logic [7:0] d_fc, s_fc;

    vga_sync_gen dut_d (
        .vga_clk(clk), .reset(reset), .DrawX(d_x), .DrawY(d_y), .hs(d_hs), .vs(d_vs),
        .blank(d_bl), .line_start(d_ls), .frame_start(d_fs), .frame_count(d_fc)
    );

    // Reduced raster: 15 clocks per line, 13 lines, 195 clocks per frame, 48 visible pixels.
    vga_sync_gen #(
        .H_VISIBLE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
        .V_VISIBLE(6), .V_FRONT(2), .V_SYNC(2), .V_BACK(3)
    ) dut_s (
        .vga_clk(clk), .reset(reset), .DrawX(s_x), .DrawY(s_y), .hs(s_hs), .vs(s_vs),
        .blank(s_bl), .line_start(s_ls), .frame_start(s_fs), .frame_count(s_fc)
    );

    int dmx, dmy, dfc, smx, smy, sfc;
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            dmx <= 799; dmy <= 524; dfc <= 0;
            smx <= 14; smy <= 12; sfc <= 0;
        end else begin
            dmx <= (dmx == 799) ? 0 : dmx + 1;
            if (dmx == 799) dmy <= (dmy == 524) ? 0 : dmy + 1;
            if (dmx == 799 && dmy == 524) dfc <= (dfc + 1) % 256;
            smx <= (smx == 14) ? 0 : smx + 1;
            if (smx == 14) smy <= (smy == 12) ? 0 : smy + 1;
            if (smx == 14 && smy == 12) sfc <= (sfc + 1) % 256;
        end
    end

    int s_blank_n, s_vs_n, s_fs_n;
    bit s_have;
    always @(negedge clk) begin
        if (reset) begin
            chk("d_rst_x", d_x, 799); chk("d_rst_y", d_y, 524); chk("d_rst_bl", d_bl, 0);
            chk("s_rst_x", s_x, 14); chk("s_rst_y", s_y, 12); chk("s_rst_fc", s_fc, 0);
            s_blank_n = 0; s_vs_n = 0; s_fs_n = 0; s_have = 0;
        end else begin
            chk("d_x", d_x, dmx);
            chk("d_y", d_y, dmy);
            chk("d_hs", d_hs, (dmx >= 656 && dmx <= 751) ? 0 : 1);
            chk("d_vs", d_vs, (dmy >= 490 && dmy <= 491) ? 0 : 1);
            chk("d_blank", d_bl, (dmx < 640 && dmy < 480) ? 1 : 0);
            chk("d_line_start", d_ls, dmx == 0 ? 1 : 0);
            chk("d_frame_start", d_fs, (dmx == 0 && dmy == 0) ? 1 : 0);
            chk("d_frame_count", d_fc, dfc);
            chk("s_x", s_x, smx);
            chk("s_y", s_y, smy);
            chk("s_hs", s_hs, (smx >= 10 && smx <= 12) ? 0 : 1);
            chk("s_vs", s_vs, (smy >= 8 && smy <= 9) ? 0 : 1);
            chk("s_blank", s_bl, (smx < 8 && smy < 6) ? 1 : 0);
            chk("s_line_start", s_ls, smx == 0 ? 1 : 0);
            chk("s_frame_start", s_fs, (smx == 0 && smy == 0) ? 1 : 0);
            chk("s_frame_count", s_fc, sfc);
            if (s_fs) begin
                s_fs_n++;
                if (s_have) begin
                    chk("s_frame_blank_cycles", s_blank_n, 48);
                    chk("s_frame_vs_low_cycles", s_vs_n, 30);
                end
                s_have = 1;
                s_blank_n = 0;
                s_vs_n = 0;
            end
            if (s_bl) s_blank_n++;
            if (!s_vs) s_vs_n++;
        end
    end

    typedef struct {
        int n; int x; int y; int hs; int vs; int bl; int ls; int fs; int fc;
    } vec_t;
    vec_t tv[12];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int n, lo, first, falls, prev;
        bit hit;
        tv[0]  = '{1,    0,   0, 1, 1, 1, 1, 1, 1};
        tv[1]  = '{2,    1,   0, 1, 1, 1, 0, 0, 1};
        tv[2]  = '{640,  639, 0, 1, 1, 1, 0, 0, 1};
        tv[3]  = '{641,  640, 0, 1, 1, 0, 0, 0, 1};
        tv[4]  = '{656,  655, 0, 1, 1, 0, 0, 0, 1};
        tv[5]  = '{657,  656, 0, 0, 1, 0, 0, 0, 1};
        tv[6]  = '{752,  751, 0, 0, 1, 0, 0, 0, 1};
        tv[7]  = '{753,  752, 0, 1, 1, 0, 0, 0, 1};
        tv[8]  = '{800,  799, 0, 1, 1, 0, 0, 0, 1};
        tv[9]  = '{801,  0,   1, 1, 1, 1, 1, 0, 1};
        tv[10] = '{1440, 639, 1, 1, 1, 1, 0, 0, 1};
        tv[11] = '{1601, 0,   2, 1, 1, 1, 1, 0, 1};

        #1 reset = 1'b1;
        #2;
        chk("rst_x", d_x, 799); chk("rst_y", d_y, 524); chk("rst_hs", d_hs, 1);
        chk("rst_vs", d_vs, 1); chk("rst_blank", d_bl, 0); chk("rst_ls", d_ls, 0);
        chk("rst_fs", d_fs, 0); chk("rst_fc", d_fc, 0);
        @(negedge clk);
        #1 reset = 1'b0;

        n = 0;
        for (int i = 0; i < 12; i++) begin
            while (n < tv[i].n) begin
                step();
                n++;
            end
            chk($sformatf("tv%0d_x", i), d_x, tv[i].x);
            chk($sformatf("tv%0d_y", i), d_y, tv[i].y);
            chk($sformatf("tv%0d_hs", i), d_hs, tv[i].hs);
            chk($sformatf("tv%0d_vs", i), d_vs, tv[i].vs);
            chk($sformatf("tv%0d_blank", i), d_bl, tv[i].bl);
            chk($sformatf("tv%0d_ls", i), d_ls, tv[i].ls);
            chk($sformatf("tv%0d_fs", i), d_fs, tv[i].fs);
            chk($sformatf("tv%0d_fc", i), d_fc, tv[i].fc);
        end

        lo = 0; first = -1; falls = 0; prev = 1;
        for (int k = 0; k < 800; k++) begin
            step();
            if (!d_hs) begin
                if (lo == 0) first = d_x;
                lo++;
            end
            if (prev == 1 && d_hs == 1'b0) falls++;
            prev = d_hs;
        end
        chk("line_hs_low_cycles", lo, 96);
        chk("line_hs_first_low_x", first, 656);
        chk("line_hs_pulses", falls, 1);
        chk("line_wrap_x", d_x, 0);
        chk("line_wrap_y", d_y, 3);
        chk("line_wrap_ls", d_ls, 1);

        hit = 0;
        for (int k = 0; k < 60000 && !hit; k++) begin
            @(negedge clk);
            #1;
            if (s_fc == 8'd255) hit = 1;
        end
        chk("s_reach_255", hit, 1);
        chk("s_fs_count_at_255", s_fs_n, 255);
        hit = 0;
        for (int k = 0; k < 400 && !hit; k++) begin
            @(negedge clk);
            #1;
            if (s_fs) hit = 1;
        end
        chk("s_wrap_seen", hit, 1);
        chk("s_wrap_fc", s_fc, 0);
        chk("s_wrap_fs_count", s_fs_n, 256);
        chk("s_wrap_x", s_x, 0);
        chk("s_wrap_y", s_y, 0);

        hit = 0;
        for (int k = 0; k < 900 && !hit; k++) begin
            step();
            if (d_x == 10'd300) hit = 1;
        end
        chk("reach_x300", hit, 1);
        #2 reset = 1'b1;
        #1;
        chk("async_x", d_x, 799); chk("async_y", d_y, 524); chk("async_hs", d_hs, 1);
        chk("async_vs", d_vs, 1); chk("async_blank", d_bl, 0); chk("async_ls", d_ls, 0);
        chk("async_fs", d_fs, 0); chk("async_fc", d_fc, 0);
        chk("async_s_x", s_x, 14); chk("async_s_y", s_y, 12); chk("async_s_fc", s_fc, 0);
        @(negedge clk);
        #1 reset = 1'b0;
        step();
        chk("rel_x", d_x, 0); chk("rel_y", d_y, 0); chk("rel_blank", d_bl, 1);
        chk("rel_ls", d_ls, 1); chk("rel_fs", d_fs, 1); chk("rel_fc", d_fc, 1);
        step();
        chk("rel2_x", d_x, 1); chk("rel2_fs", d_fs, 0); chk("rel2_ls", d_ls, 0);
        chk("rel2_fc", d_fc, 1);

        repeat (3) step();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/vga_sync_gen.md
VGA_SYNC_GEN -- requirements
Module: vga_sync_gen

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset: `vga_clk` is the single clock, and `reset` is asynchronous and active-high.
REQ-002 Parameter H_VISIBLE, default 640, visible pixels per line.
REQ-003 Parameter H_FRONT, default 16, horizontal front-porch clocks.
REQ-004 Parameter H_SYNC, default 96, hsync pulse clocks.
REQ-005 Parameter H_BACK, default 48, horizontal back-porch clocks (H_TOTAL = sum of the four = 800).
REQ-006 Parameter V_VISIBLE, default 480, visible lines.
REQ-007 Parameter V_FRONT, default 10, vertical front-porch lines.
REQ-008 Parameter V_SYNC, default 2, vsync pulse lines.
REQ-009 Parameter V_BACK, default 33, vertical back-porch lines (V_TOTAL = 525).
REQ-010 vga_clk  input  1  pixel clock; all state updates on its rising edge.
REQ-011 reset  input  1  asynchronous active-high reset.
REQ-012 DrawX  output  10  current horizontal pixel count, 0..H_TOTAL-1.
REQ-013 DrawY  output  10  current line count, 0..V_TOTAL-1.
REQ-014 hs  output  1  horizontal sync, active-low.
REQ-015 vs  output  1  vertical sync, active-low.
REQ-016 blank  output  1  1 = visible pixel (DrawX<H_VISIBLE and DrawY<V_VISIBLE); 0 = drive black.
REQ-017 line_start  output  1  one-cycle pulse, 1 while DrawX==0.
REQ-018 frame_start  output  1  one-cycle pulse, 1 while DrawX==0 and DrawY==0.
REQ-019 frame_count  output  8  count of frames started since reset.

Function
REQ-020 DrawX SHALL increment by 1 on every rising edge, and SHALL wrap from H_TOTAL-1 to 0.
REQ-021 DrawY SHALL increment by 1 only on the edge where DrawX wraps, and SHALL wrap from V_TOTAL-1 to 0 on that same edge.
REQ-022 All outputs SHALL be registered and mutually aligned: hs, vs, blank, line_start and frame_start in any cycle describe the DrawX/DrawY values presented in that same cycle (decode from next-count values, no output lag).
REQ-023 hs SHALL be 0 exactly for DrawX in [H_VISIBLE+H_FRONT, H_VISIBLE+H_FRONT+H_SYNC-1], i.e. 656..751; otherwise 1.
REQ-024 vs SHALL be 0 exactly for DrawY in [V_VISIBLE+V_FRONT, V_VISIBLE+V_FRONT+V_SYNC-1], i.e. 490..491, for all DrawX on those lines; otherwise 1.
REQ-025 blank SHALL be 1 for exactly 640x480 = 307200 cycles per 420000-cycle frame.
REQ-026 frame_count SHALL increment on each edge that enters (DrawX,DrawY)=(0,0), and SHALL wrap from 255 to 0.
REQ-027 The counter width arithmetic SHALL NOT overflow: comparisons use full 10-bit values, and the maximum counts are 799 and 524.
REQ-028 The block SHALL have no input handshake and no stall; the timing is free-running whenever reset is low.

Reset
REQ-029 While reset=1: DrawX=799, DrawY=524, hs=1, vs=1, blank=0, line_start=0, frame_start=0, frame_count=0, with all of these taking effect asynchronously.
REQ-030 On the first rising edge after reset deassertion, the outputs SHALL be DrawX=0, DrawY=0, blank=1, line_start=1, frame_start=1, frame_count=1.
REQ-031 Reset asserted mid-frame SHALL force the REQ-029 values immediately, without waiting for a clock edge, and the timing SHALL restart per REQ-030.

Verification
REQ-032 Release reset, then run 1 edge -> (0,0), blank=1, frame_start=1, frame_count=1; then run 1 more edge -> DrawX=1, frame_start=0, line_start=0.
REQ-033 Run 800 edges from (0,0) -> hs low for exactly 96 consecutive cycles starting at DrawX=656; (799,0) is followed by (0,1) with line_start=1.
REQ-034 Run one full frame of 420000 edges -> blank high for 307200 cycles; vs low for 1600 cycles on lines 490..491; (799,524) is followed by (0,0) with frame_count=2.
REQ-035 Run 256 frames after reset -> frame_count sequence ...,255,0,... with the wrap occurring at the 256th frame_start.
REQ-036 Assert reset asynchronously at DrawX=300, DrawY=200, between clock edges -> outputs reach the REQ-029 values before the next edge; after release, REQ-030 holds.
REQ-037 At every cycle a checker model SHALL confirm hs, vs and blank against DrawX/DrawY per REQ-023, REQ-024 and REQ-016, with no one-cycle misalignment.
